regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file, the successor to the single-port `regfile` block. It provides one byte-enabled write port and NUM_RD independent combinational read ports, with same-cycle write-to-read bypass and an optional hard-wired zero entry. Instead of a parallel reset, it clears its storage with a sequential walk after reset, so it maps to plain flops or distributed RAM. It sits in the datapath wherever a small addressed storage array feeds execution units.

## Interface
Parameters:
- DATA_W, 32, entry width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; must be ≥ 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable, active high.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables; bit b covers wdata[8b+7:8b].
- raddr  in  NUM_RD*ADDR_W  read addresses; port p uses slice [p*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port p uses slice [p*DATA_W +: DATA_W].
- init_busy  out  1  high while the clear walk is in progress.

## Operation
- FSM with two states:
  - ST_INIT: clear walk, one entry per cycle.
  - ST_RUN: normal operation.
- Reset:
  - While reset is high: state = ST_INIT, clear counter cnt = 0, init_busy = 1.
  - Array contents are not touched during reset.
- ST_INIT:
  - Each rising edge with reset low writes 0 to entry cnt, then increments cnt.
  - The edge that clears entry DEPTH-1 moves the FSM to ST_RUN.
  - Writes arriving in ST_INIT are dropped silently.
  - Every rdata port reads 0 during ST_INIT.
- ST_RUN writes:
  - When we = 1, each byte b with wbe[b] = 1 is updated at the edge; other bytes keep their value.
  - we = 1 with wbe = 0 is a no-op.
- ST_RUN reads:
  - rdata is combinational from raddr.
  - If we = 1 and raddr == waddr in the same cycle, rdata returns the merged value: enabled bytes from wdata, the rest from the array (write-first bypass).
- ZERO_REG = 1:
  - Reads of address 0 return 0, including when bypassed.
  - Writes to address 0 are discarded.
  - The clear walk still visits entry 0.
- Addresses ≥ DEPTH (non-power-of-2 DEPTH only):
  - Writes are discarded.
  - Reads return 0.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.

## Timing
- Reset values:
  - init_busy = 1.
  - rdata = 0 on all ports.
- Clear walk latency:
  - init_busy stays high for exactly DEPTH rising edges after reset falls.
  - It drops in the cycle after entry DEPTH-1 is cleared.
  - The first accepted write is in cycle DEPTH+1 after reset release, counting the first post-reset edge as cycle 1.
- Write-to-read latency:
  - 0 cycles through the bypass.
  - From the next cycle, the array itself returns the value.
- Reset mid-walk: cnt returns to 0 and the walk restarts from entry 0 once reset falls.
- Reset in ST_RUN:
  - Returns the FSM to ST_INIT.
  - Prior contents are cleared by the new walk.
- Reset and we together: reset wins and the write is dropped.
- cnt width is ADDR_W. Wrap-around never occurs, because the FSM leaves ST_INIT at DEPTH-1.

## Structure
- Shared package `regfile_pkg` holds:
  - the `rf_state_t` enum (ST_INIT, ST_RUN);
  - the `ENABLE` / `DISABLE` constants;
  - the byte-merge function used by both the write path and the bypass.
- One sub-module, `regfile_init_ctl`, contains the FSM and counter. Its outputs are init_busy, clr_we and clr_addr.
- The top level contains:
  - the array;
  - the write mux that selects between the clear walk and the user port;
  - a generate loop over NUM_RD read ports.

## Test plan
- Clear walk (DEPTH=32): hold reset for 3 cycles, then release → init_busy stays 1 for 32 edges then goes 0. A write of 0xDEADBEEF to addr 5 at edge 10 is dropped. raddr0 = 5 then reads 0 after the walk.
- Byte-enable write (after init):
  - Write 0x11223344 to addr 7 with wbe = 0xF.
  - Write 0xAABBCCDD to addr 7 with wbe = 0x5.
  - Next cycle, reading addr 7 must return 0x11BB33DD.
- Bypass: with addr 9 = 0x0, drive we = 1, waddr = 9, wdata = 0xCAFEF00D, wbe = 0xC, and raddr0 = raddr1 = 9 → both ports read 0xCAFE0000 in the same cycle.
- Zero register:
  - Write 0xFFFFFFFF to addr 0 → reads of addr 0 return 0, both same-cycle and next cycle.
  - With ZERO_REG = 0, the same write reads back 0xFFFFFFFF.
- Reset mid-walk: assert reset at walk edge 12 for 1 cycle → init_busy stays high for another full 32 edges, and every entry reads 0 afterwards.
- Reset in ST_RUN:
  - Fill all 32 entries with their own index.
  - Pulse reset → init_busy is high for 32 cycles, then all entries read 0.
  - A write issued in the same cycle as reset is dropped.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // One byte of a byte-enabled write: new byte when enabled, old byte otherwise.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write port, read ports and init status of the multi-port register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [DATA_W/8-1:0]      wbe;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     init_busy;

  modport master (output we, waddr, wdata, wbe, raddr, input rdata, init_busy);
  modport slave  (input we, waddr, wdata, wbe, raddr, output rdata, init_busy);

endinterface

// File: rtl/regfile_init_ctl.sv
// Post-reset clear walk: zeroes one entry per cycle, then hands over to normal use.
//
// state   | meaning
// --------+------------------------------------------------
// ST_INIT | clearing entry cnt this cycle; user port blocked
// ST_RUN  | walk finished; user writes and reads live
module regfile_init_ctl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and walk counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; reset forces busy and suppresses the clear so the array is untouched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_busy = DISABLE;
    clr_we    = DISABLE;
    clr_addr  = cnt_q;
    if (reset) begin
      init_busy = ENABLE;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_busy = ENABLE;
          clr_we    = ENABLE;
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one byte-enabled write port, NUM_RD combinational
// read ports with write-first bypass, optional hard-wired zero entry.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int NB      = DATA_W / 8
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              init_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              waddr_ok;
  logic              usr_wr;
  logic [DATA_W-1:0] wr_merge;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_val;
  logic [NUM_RD*DATA_W-1:0] rdata_all;

  regfile_init_ctl #(.DEPTH(DEPTH)) u_init_ctl (
    .clk       (clk),
    .reset     (reset),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign bus.init_busy = init_busy;

  // init_busy already covers reset, so writes during reset are dropped too.
  assign waddr_ok = ({1'b0, bus.waddr} < DEPTH_L) &&
                    !((ZERO_REG != 0) && (bus.waddr == '0));
  assign usr_wr   = bus.we && !init_busy && waddr_ok;

  // Stored word with enabled bytes replaced; feeds both the write and the bypass.
  always_comb begin
    wr_merge = mem_q[bus.waddr];
    for (int b = 0; b < NB; b++) begin
      wr_merge[8*b +: 8] = byte_merge(mem_q[bus.waddr][8*b +: 8],
                                      bus.wdata[8*b +: 8], bus.wbe[b]);
    end
  end

  // Write source select: clear walk owns the port until it finishes.
  always_comb begin
    wr_en  = DISABLE;
    wr_idx = clr_addr;
    wr_val = '0;
    if (clr_we) begin
      wr_en = ENABLE;
    end else if (usr_wr) begin
      wr_en  = ENABLE;
      wr_idx = bus.waddr;
      wr_val = wr_merge;
    end
  end

  // Storage array; deliberately no reset so it maps to plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_val;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.raddr[p*ADDR_W +: ADDR_W];

    // Read port: zero while busy, for the zero entry and out-of-range; else bypass or array.
    always_comb begin
      rd = '0;
      if (!init_busy && ({1'b0, ra} < DEPTH_L) &&
          !((ZERO_REG != 0) && (ra == '0))) begin
        if (bus.we && (ra == bus.waddr)) begin
          rd = wr_merge;
        end else begin
          rd = mem_q[ra];
        end
      end
    end

    assign rdata_all[p*DATA_W +: DATA_W] = rd;
  end

  assign bus.rdata = rdata_all;

endmodule
